dtm_mac_seq: RTL and testbench
==============================

DTM_MAC_SEQ -- requirements
Module: dtm_mac_seq

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8, the operand and product width of the shared DTM multiplier.
REQ-002 SHALL have parameter ACC_WIDTH, default 24, the accumulator and result width (ACC_WIDTH >= BITWIDTH).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, the element-counter width.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand pair valid.
REQ-007 in_ready  output  1  sequencer accepts the operand pair.
REQ-008 in_a  input  BITWIDTH  operand a (unsigned).
REQ-009 in_b  input  BITWIDTH  operand b (unsigned).
REQ-010 in_last  input  1  pair is the final element of the vector.
REQ-011 flush  input  1  synchronous abort of the current vector.
REQ-012 mul_a  output  BITWIDTH  operand a to the external combinational DTM multiplier.
REQ-013 mul_b  output  BITWIDTH  operand b to the external DTM multiplier.
REQ-014 mul_r  input  BITWIDTH  truncated approximate product returned by the DTM multiplier in the same cycle.
REQ-015 out_valid  output  1  dot-product result valid.
REQ-016 out_ready  input  1  consumer accepts the result.
REQ-017 out_data  output  ACC_WIDTH  accumulated dot product.
REQ-018 out_count  output  CNT_WIDTH  number of elements accumulated.
REQ-019 out_sat  output  1  accumulator or counter saturated during this vector.

Function
REQ-020 SHALL implement states IDLE, ACCUM, DRAIN and OUTPUT.
REQ-021 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DRAIN and OUTPUT.
REQ-022 A pair SHALL be accepted on a rising edge where in_valid && in_ready; accepted in_a/in_b SHALL be registered into an operand stage that drives mul_a/mul_b, with a stage-valid bit and the last flag.
REQ-023 While stage-valid is 1, the edge following acceptance SHALL add zero-extended mul_r to the accumulator and increment the counter; stage-valid SHALL clear unless a new pair is accepted on that edge.
REQ-024 mul_a/mul_b SHALL hold their last value when stage-valid is 0.
REQ-025 Transitions: IDLE->ACCUM on acceptance without last; IDLE or ACCUM->DRAIN on acceptance with in_last=1; DRAIN->OUTPUT unconditionally after one cycle; OUTPUT->IDLE on out_valid && out_ready.
REQ-026 out_valid SHALL equal (state == OUTPUT); out_data, out_count and out_sat SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 Latency: a last pair accepted at edge k SHALL produce out_valid=1 after edge k+1.
REQ-028 Accumulation SHALL saturate at 2^ACC_WIDTH-1 and the counter at 2^CNT_WIDTH-1; either event SHALL set out_sat, which holds until the vector completes.
REQ-029 The OUTPUT->IDLE transition SHALL clear the accumulator, counter, out_sat and stage-valid.
REQ-030 flush=1 SHALL force IDLE, clear the accumulator, counter, out_sat and stage-valid, and suppress acceptance on that edge; flush has priority over every other event, including out_ready in OUTPUT.
REQ-031 A single-element vector (in_last=1 accepted in IDLE) SHALL yield out_count=1 and out_data=mul_r for that pair.
REQ-032 A pair accepted in the same cycle that the previous pair's product is accumulated SHALL not lose either product (full throughput, one pair per cycle).

Reset
REQ-033 On rst_n=0, state SHALL be IDLE and in_ready=1; out_valid, out_data, out_count, out_sat, stage-valid, mul_a and mul_b SHALL all be 0, regardless of clk.
REQ-034 Reset asserted mid-vector or in OUTPUT SHALL discard the partial result; no out_valid SHALL follow reset release until a new last pair is accepted.

Verification
REQ-035 Back-to-back pairs (3,4),(5,6),(7,8 last) with exact-multiplier model, out_ready=1 -> out_valid one cycle after the last acceptance, out_data=12+30+56=98, out_count=3, out_sat=0.
REQ-036 Single pair (255,255 last) with BITWIDTH=8 -> out_count=1, out_data equal to the mul_r value presented for that pair.
REQ-037 ACC_WIDTH=8 with a mul_r stub returning 200 for 2 pairs -> out_data=255, out_sat=1.
REQ-038 out_ready held at 0 for 5 cycles in OUTPUT -> in_ready=0 and out_data stable throughout, IDLE on the first cycle after out_ready=1.
REQ-039 flush asserted after 2 pairs of a 4-pair vector, then a new 2-pair vector -> result reflects only the new vector, out_count=2.
REQ-040 rst_n pulsed low while in ACCUM -> all outputs 0 immediately; the next vector (2,2),(3,3 last) gives out_data=13.

Source files
------------

// File: rtl/dtm_mac_seq.sv
// Dot-product sequencer around an external combinational DTM multiplier.
// Operand pairs are staged into registers that drive mul_a/mul_b. The
// truncated product mul_r is added into a saturating accumulator on the
// following edge. A vector ends with the pair flagged in_last. The result
// is then held until the consumer accepts it.
module dtm_mac_seq #(
    parameter int unsigned BITWIDTH  = 8,
    parameter int unsigned ACC_WIDTH = 24,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BITWIDTH-1:0]  in_a,
    input  logic [BITWIDTH-1:0]  in_b,
    input  logic                 in_last,
    input  logic                 flush,
    output logic [BITWIDTH-1:0]  mul_a,
    output logic [BITWIDTH-1:0]  mul_b,
    input  logic [BITWIDTH-1:0]  mul_r,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_sat
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] OUTPUT = 2'd3;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic                 stg_valid;
    logic [BITWIDTH-1:0]  stg_a;
    logic [BITWIDTH-1:0]  stg_b;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 sat;

    logic                 accept;
    logic                 done;
    logic [ACC_WIDTH:0]   prod_ext;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 acc_ovf;
    logic                 cnt_max;
    logic [CNT_WIDTH-1:0] cnt_next;

    assign in_ready  = (state == IDLE) || (state == ACCUM);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state == OUTPUT);
    assign done      = out_valid && out_ready;
    assign mul_a     = stg_a;
    assign mul_b     = stg_b;
    assign out_data  = acc;
    assign out_count = cnt;
    assign out_sat   = sat;

    // Saturating add of the zero-extended product and saturating count
    always_comb begin
        prod_ext                = '0;
        prod_ext[BITWIDTH-1:0]  = mul_r;
        sum                     = {1'b0, acc} + prod_ext;
        acc_ovf                 = sum[ACC_WIDTH];
        acc_next                = acc_ovf ? '1 : sum[ACC_WIDTH-1:0];
        cnt_max                 = &cnt;
        cnt_next                = cnt_max ? cnt : cnt + 1'b1;
    end

    // Next-state logic; the last flag of the staged pair is carried by
    // DRAIN itself, since the only staged pair in DRAIN is the last one
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = in_last ? DRAIN : ACCUM;
            ACCUM:   if (accept && in_last) state_next = DRAIN;
            DRAIN:   state_next = OUTPUT;
            OUTPUT:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; flush overrides every other transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand stage feeding the multiplier; operands hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= 1'b0;
            stg_a     <= '0;
            stg_b     <= '0;
        end else if (flush) begin
            stg_valid <= 1'b0;
        end else begin
            stg_valid <= accept;
            if (accept) begin
                stg_a <= in_a;
                stg_b <= in_b;
            end
        end
    end

    // Accumulator, element counter and sticky saturation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (flush || done) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (stg_valid) begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (acc_ovf || cnt_max) sat <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dtm_mac_seq.sv
// Directed bench for dtm_mac_seq. dut drives an exact truncating 8-bit
// multiplier. dut8 (ACC_WIDTH=8) shares the control inputs. Its multiplier
// is a stub that always returns 200, which exercises accumulator saturation.
module tb_dtm_mac_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        in_last = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_sat;
    logic [7:0]  mul_a, mul_b, mul_r;
    logic [23:0] out_data;
    logic [15:0] out_count;
    logic [15:0] prod;

    logic        in_ready8, out_valid8, out_sat8;
    logic [7:0]  mul_a8, mul_b8;
    logic [7:0]  mul_r8;
    logic [7:0]  out_data8;
    logic [15:0] out_count8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        prod  = mul_a * mul_b;
        mul_r = prod[7:0];
    end
    assign mul_r8 = 8'd200;

    dtm_mac_seq #(.BITWIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .flush(flush),
        .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_sat(out_sat)
    );

    dtm_mac_seq #(.BITWIDTH(8), .ACC_WIDTH(8), .CNT_WIDTH(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .flush(flush),
        .mul_a(mul_a8), .mul_b(mul_b8), .mul_r(mul_r8),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
        .out_count(out_count8), .out_sat(out_sat8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance one edge, land 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        step();
    endtask

    task automatic stop_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        // reset state, checked without any clock edge
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_mul_b", 32'(mul_b), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // back-to-back (3,4),(5,6),(7,8 last)
        send(8'd3, 8'd4, 1'b0);
        chk("b2b_in_ready_accum", 32'(in_ready), 32'd1);
        send(8'd5, 8'd6, 1'b0);
        send(8'd7, 8'd8, 1'b1);
        stop_in();
        chk("b2b_drain_in_ready", 32'(in_ready), 32'd0);
        chk("b2b_drain_no_valid", 32'(out_valid), 32'd0);
        chk("b2b_mul_a_last", 32'(mul_a), 32'd7);
        step();
        chk("b2b_out_valid", 32'(out_valid), 32'd1);
        chk("b2b_out_data", 32'(out_data), 32'd98);
        chk("b2b_out_count", 32'(out_count), 32'd3);
        chk("b2b_out_sat", 32'(out_sat), 32'd0);
        step();
        chk("b2b_back_idle", 32'(out_valid), 32'd0);
        chk("b2b_cleared", 32'(out_data), 32'd0);
        chk("b2b_mul_a_hold", 32'(mul_a), 32'd7);

        // single pair (255,255 last): truncated product 65025 mod 256 = 1
        send(8'd255, 8'd255, 1'b1);
        stop_in();
        step();
        chk("single_out_valid", 32'(out_valid), 32'd1);
        chk("single_out_count", 32'(out_count), 32'd1);
        chk("single_out_data", 32'(out_data), 32'd1);
        chk("single8_out_data", 32'(out_data8), 32'd200);
        chk("single8_out_sat", 32'(out_sat8), 32'd0);
        step();

        // two pairs: dut8 accumulates 200+200 and saturates at 255
        send(8'd1, 8'd1, 1'b0);
        send(8'd1, 8'd1, 1'b1);
        stop_in();
        step();
        chk("sat8_out_valid", 32'(out_valid8), 32'd1);
        chk("sat8_out_data", 32'(out_data8), 32'd255);
        chk("sat8_out_sat", 32'(out_sat8), 32'd1);
        chk("sat8_out_count", 32'(out_count8), 32'd2);
        chk("nosat_out_data", 32'(out_data), 32'd2);
        chk("nosat_out_sat", 32'(out_sat), 32'd0);
        step();
        chk("sat8_cleared", 32'(out_sat8), 32'd0);

        // backpressure: hold OUTPUT for 5 cycles
        out_ready = 1'b0;
        send(8'd2, 8'd3, 1'b1);
        stop_in();
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_data", 32'(out_data), 32'd6);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_released_idle", 32'(out_valid), 32'd0);
        chk("bp_released_ready", 32'(in_ready), 32'd1);

        // flush after 2 pairs, with a pair offered on the flush edge
        send(8'd1, 8'd1, 1'b0);
        send(8'd2, 8'd2, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_a     = 8'd3;
        in_b     = 8'd3;
        step();
        flush = 1'b0;
        stop_in();
        chk("flush_count", 32'(out_count), 32'd0);
        chk("flush_data", 32'(out_data), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("flush_no_accum", 32'(out_count), 32'd0);
        send(8'd4, 8'd5, 1'b0);
        send(8'd6, 8'd7, 1'b1);
        stop_in();
        step();
        chk("flush_new_valid", 32'(out_valid), 32'd1);
        chk("flush_new_data", 32'(out_data), 32'd62);
        chk("flush_new_count", 32'(out_count), 32'd2);
        step();

        // flush wins over out_ready in OUTPUT
        out_ready = 1'b0;
        send(8'd5, 8'd5, 1'b1);
        stop_in();
        step();
        chk("flush_out_pre", 32'(out_valid), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        out_ready = 1'b1;
        chk("flush_out_idle", 32'(out_valid), 32'd0);
        chk("flush_out_data", 32'(out_data), 32'd0);

        // asynchronous reset mid-vector
        send(8'd9, 8'd9, 1'b0);
        send(8'd1, 8'd1, 1'b0);
        stop_in();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_out_count", 32'(out_count), 32'd0);
        chk("arst_mul_a", 32'(mul_a), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("arst_no_valid", 32'(out_valid), 32'd0);
        send(8'd2, 8'd2, 1'b0);
        send(8'd3, 8'd3, 1'b1);
        stop_in();
        step();
        chk("arst_next_valid", 32'(out_valid), 32'd1);
        chk("arst_next_data", 32'(out_data), 32'd13);
        chk("arst_next_count", 32'(out_count), 32'd2);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
